md_sched: RTL
=============

# md_sched

Multiply/divide sequencer for the pipelined MIPS core. It accepts decoded mult/multu/div/divu/mthi/mtlo operations from the EX stage and computes results into shadow registers. It models the fixed multi-cycle latency with a busy counter, commits HI/LO at completion, and raises the decode-stage stall for any HI/LO-class instruction that would collide with an operation in flight.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for mult/multu (legal range 1–15).
- `DIV_CYCLES`, default 10: busy cycles for div/divu (legal range 1–15).

Ports:
- `clk`  in  1  Core clock; all state updates on the rising edge.
- `rst_n`  in  1  Reset, asynchronous, active-low.
- `e_valid`  in  1  EX-stage instruction valid and not bubbled.
- `e_op`  in  3  Operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
- `e_a`  in  32  rs operand (forwarded).
- `e_b`  in  32  rt operand (forwarded).
- `cancel`  in  1  Exception/interrupt flush from the CP0 path.
- `d_is_md`  in  1  ID-stage instruction is in {mult, multu, div, divu, mthi, mtlo, mfhi, mflo}.
- `busy`  out  1  Operation in flight.
- `md_stall`  out  1  Stall request for the ID stage.
- `hi`  out  32  Architectural HI.
- `lo`  out  32  Architectural LO.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, 4-bit counter `cnt`.
- Launch: in IDLE, with `e_valid`=1, `e_op` in 1..4, and `cancel`=0:
  - Capture the 64-bit result into `hi_sh`/`lo_sh`.
  - Load `cnt` = `MULT_CYCLES` or `DIV_CYCLES`; go to RUN.
- Arithmetic:
  - mult: signed 32×32→64; `{hi_sh,lo_sh}` = product.
  - multu: unsigned 32×32→64.
  - div: `lo_sh` = quotient truncated toward zero; `hi_sh` = remainder carrying the dividend's sign. 0x80000000 / 0xFFFFFFFF gives `lo_sh`=0x80000000, `hi_sh`=0.
  - divu: unsigned quotient and remainder.
  - Divisor 0 (div/divu): the operation still runs its full latency, but the commit leaves HI/LO unchanged.
- RUN: `cnt` decrements each cycle. When `cnt`=1, the next edge writes `hi`←`hi_sh` and `lo`←`lo_sh` and returns to IDLE.
- mthi/mtlo, accepted only in IDLE with `cancel`=0: the next edge writes `hi`←`e_a` (mthi) or `lo`←`e_a` (mtlo).
- Any `e_op` other than none while in RUN is ignored; upstream guarantees this never happens via `md_stall`.
- `md_stall` = `d_is_md` & (`busy` | (`e_valid` & `e_op` in 1..4)). This is combinational, with no register in the path.

## Timing
- Reset: `busy`=0, `cnt`=0, `hi`=0, `lo`=0, shadow registers 0, state IDLE. Reset takes effect immediately, independent of `clk`.
- Reset asserted mid-RUN aborts the operation; no commit occurs.
- Launch edge is cycle 0. `busy`=1 during cycles 1..N, where N is the latency. HI/LO take the new values and `busy`=0 from cycle N+1.
- mthi/mtlo: the new value is visible one cycle after the accept edge.
- `cancel` and launch in the same cycle: no launch.
- `cancel` while `busy`=0: no effect.

## Configuration
- `MD_CANCEL_EN` defined: `cancel`=1 while in RUN aborts the operation on that edge. The state returns to IDLE, `busy`=0 on the next cycle, and HI/LO keep their pre-launch values.
- `MD_CANCEL_EN` undefined: `cancel` is ignored while in RUN, and an in-flight operation always commits. `cancel` still blocks new launches and mthi/mtlo writes in either build.

## Test plan
- Reset, then mult with `e_a`=0xFFFFFFFF and `e_b`=2: `busy` high for 5 cycles; then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE.
- multu with the same operands: `hi`=0x00000001, `lo`=0xFFFFFFFE after 5 cycles.
- div with `e_a`=0xFFFFFFF9 (−7) and `e_b`=2: `busy` high for 10 cycles; then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. Divu 7/0 leaves prior HI/LO unchanged after 10 cycles.
- Launch mult with `d_is_md`=1 (an mflo behind it): `md_stall`=1 in the launch cycle and the 5 busy cycles, 0 in cycle 6. With `d_is_md`=0, `md_stall` stays 0 throughout.
- mthi with `e_a`=0x12345678 in IDLE: `hi`=0x12345678 next cycle. mtlo while busy: `lo` unchanged.
- Launch div, then `cancel`=1 at cycle 3:
  - With `MD_CANCEL_EN`: `busy`=0 at cycle 4 and HI/LO hold their old values.
  - Without it: the commit happens at cycle 11.
  - Either build: `rst_n` pulsed low at cycle 2 clears `hi`/`lo`/`busy` immediately.

Source files
------------

// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer for the pipelined MIPS core.
// Results go into shadow registers at launch and reach HI/LO only after the
// modelled latency. Optional build macro MD_CANCEL_EN lets a CP0 flush abort an
// operation in flight. Without the macro, a started operation always commits.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_valid,
  input  logic [2:0]  e_op,
  input  logic [31:0] e_a,
  input  logic [31:0] e_b,
  input  logic        cancel,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_dz;
  logic [31:0] r_hi_sh;
  logic [31:0] r_lo_sh;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_is_arith;
  logic        w_idle_ok;
  logic        w_launch;
  logic        w_mthi;
  logic        w_mtlo;
  logic signed [63:0] w_sa;
  logic signed [63:0] w_sb;
  logic signed [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic [63:0] w_res;
  logic [3:0]  w_lat;
  logic        w_dz;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. -2^31 / -1 wraps to 0x80000000 with remainder 0.
  // A zero divisor is replaced by 1 only to keep the datapath defined; the
  // result is discarded at commit.
  function automatic logic [63:0] f_sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? (~a + 32'd1) : a;
    ub = b[31] ? (~b + 32'd1) : b;
    if (ub == 32'd0) ub = 32'd1;
    q = ua / ub;
    r = ua % ub;
    if (a[31] ^ b[31]) q = ~q + 32'd1;
    if (a[31]) r = ~r + 32'd1;
    return {r, q};
  endfunction

  // Unsigned divide, returns {remainder, quotient}.
  function automatic logic [63:0] f_udiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ub;
    ub = (b == 32'd0) ? 32'd1 : b;
    return {a % ub, a / ub};
  endfunction

  assign w_is_arith = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
  assign w_idle_ok  = (r_state == S_IDLE) && e_valid && !cancel;
  assign w_launch   = w_idle_ok && w_is_arith;
  assign w_mthi     = w_idle_ok && (e_op == OP_MTHI);
  assign w_mtlo     = w_idle_ok && (e_op == OP_MTLO);

  assign w_sa    = {{32{e_a[31]}}, e_a};
  assign w_sb    = {{32{e_b[31]}}, e_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {32'd0, e_a} * {32'd0, e_b};

  // Select the 64-bit {hi,lo} result, latency and divide-by-zero flag for the launching op.
  always_comb begin
    w_res = 64'd0;
    w_lat = MULT_CNT;
    w_dz  = 1'b0;
    case (e_op)
      OP_MULT:  w_res = w_sprod;
      OP_MULTU: w_res = w_uprod;
      OP_DIV: begin
        w_res = f_sdiv(e_a, e_b);
        w_lat = DIV_CNT;
        w_dz  = (e_b == 32'd0);
      end
      OP_DIVU: begin
        w_res = f_udiv(e_a, e_b);
        w_lat = DIV_CNT;
        w_dz  = (e_b == 32'd0);
      end
      default: ;
    endcase
  end

  // Sequencer: launch into shadow registers, count down, commit to HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_dz    <= 1'b0;
      r_hi_sh <= 32'd0;
      r_lo_sh <= 32'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_hi_sh <= w_res[63:32];
            r_lo_sh <= w_res[31:0];
            r_dz    <= w_dz;
            r_cnt   <= w_lat;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else if (w_mthi) begin
            r_hi <= e_a;
          end else if (w_mtlo) begin
            r_lo <= e_a;
          end
        end
        S_RUN: begin
`ifdef MD_CANCEL_EN
          if (cancel) begin
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else
`endif
          if (r_cnt == 4'd1) begin
            if (!r_dz) begin
              r_hi <= r_hi_sh;
              r_lo <= r_lo_sh;
            end
            r_cnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign md_stall = d_is_md && (r_busy || (e_valid && w_is_arith));

endmodule
